// File: rtl/schmidl_cox_preamble_inserter_if.sv
// AXI-Stream [I,Q] link used on both sides of the preamble inserter.
//   tdata  : sample {I[31:16], Q[15:0]}, 16-bit signed each
//   tlast  : last beat of a packet/frame
//   tvalid : source has a beat
//   tready : sink takes the beat
// master modport drives data/last/valid; slave modport drives ready.
interface schmidl_cox_preamble_inserter_if;
  logic [31:0] tdata;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/schmidl_cox_preamble_inserter.sv
// Schmidl-Cox training-symbol inserter (TX side).
// Prepends cyclic prefix + two identical half-symbols, read from a small preamble RAM, to every
// payload packet, then passes the payload through. One registered output stage.
//
// Optional feature: define SC_PREAMBLE_CP_EN to emit the cyclic prefix (CP_LEN beats taken from
// the tail of the half-symbol). Without it the CP state does not exist and CP_LEN is ignored.
//
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   clear           : synchronous soft clear (FSM to idle, output register dropped, RAM kept)
//   pre_wr_en/addr/data : preamble RAM write port, only honoured while idle
//   pre_wr_err      : one-cycle pulse after a rejected write
//   i_axis          : payload input stream (slave)
//   o_axis          : framed output stream (master)
//   busy            : high whenever the FSM is not idle
// Requires FFT_SIZE >= 4 (power of two) and 1 <= CP_LEN <= FFT_SIZE/2.
module schmidl_cox_preamble_inserter #(
  parameter int unsigned FFT_SIZE = 1024,
  parameter int unsigned CP_LEN   = 128
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            pre_wr_en,
  input  logic [$clog2(FFT_SIZE/2)-1:0]   pre_wr_addr,
  input  logic [31:0]                     pre_wr_data,
  output logic                            pre_wr_err,
  schmidl_cox_preamble_inserter_if.slave  i_axis,
  schmidl_cox_preamble_inserter_if.master o_axis,
  output logic                            busy
);

  localparam int unsigned HALF_FFT_SIZE = FFT_SIZE / 2;
  localparam int unsigned AddrW         = $clog2(HALF_FFT_SIZE);
  // Counter must hold either terminal count.
  localparam int unsigned CntMax = (CP_LEN > HALF_FFT_SIZE) ? CP_LEN : HALF_FFT_SIZE;
  localparam int unsigned CntW   = $clog2(CntMax);

  localparam logic [CntW-1:0] HalfLast = CntW'(HALF_FFT_SIZE - 1);
`ifdef SC_PREAMBLE_CP_EN
  localparam logic [CntW-1:0]  CpLast = CntW'(CP_LEN - 1);
  // CP is the tail of the half-symbol.
  localparam logic [AddrW-1:0] CpBase = AddrW'(HALF_FFT_SIZE - CP_LEN);
`endif

  typedef enum logic [2:0] {
    StIdle,
`ifdef SC_PREAMBLE_CP_EN
    StCp,
`endif
    StHalf0,
    StHalf1,
    StPayload
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     o_tdata_q;
  logic            o_tlast_q;
  logic            o_tvalid_q;
  logic            pre_wr_err_q;

  logic [31:0]     ram [HALF_FFT_SIZE];
  logic [AddrW-1:0] rd_addr;
  logic [31:0]     rd_data;
  logic            out_free;
  logic            start;
  logic            wr_ok;
  logic            in_ready;
  logic            in_fire;

  // Output register can take a new sample this cycle.
  assign out_free = !o_tvalid_q || o_axis.tready;
  assign start    = (state_q == StIdle) && i_axis.tvalid && !clear;
  // Writes only land while idle and not in the cycle the frame starts.
  assign wr_ok    = (state_q == StIdle) && !start;
  // clear gates ready so a beat is never taken and then thrown away.
  assign in_ready = (state_q == StPayload) && out_free && !clear;
  assign in_fire  = in_ready && i_axis.tvalid;

  always_comb begin
    rd_addr = AddrW'(cnt_q);
`ifdef SC_PREAMBLE_CP_EN
    if (state_q == StCp) begin
      rd_addr = CpBase + AddrW'(cnt_q);
    end
`endif
  end

  assign rd_data = ram[rd_addr];

  // Preamble RAM: no reset, contents survive reset and clear.
  always_ff @(posedge clk) begin
    if (pre_wr_en && wr_ok) begin
      ram[pre_wr_addr] <= pre_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      o_tdata_q    <= '0;
      o_tlast_q    <= 1'b0;
      o_tvalid_q   <= 1'b0;
      pre_wr_err_q <= 1'b0;
    end else begin
      pre_wr_err_q <= pre_wr_en && !wr_ok;
      if (clear) begin
        state_q    <= StIdle;
        cnt_q      <= '0;
        o_tlast_q  <= 1'b0;
        o_tvalid_q <= 1'b0;
      end else begin
        // Register drains by default; a state that produces a sample overrides below.
        if (out_free) begin
          o_tvalid_q <= 1'b0;
          o_tlast_q  <= 1'b0;
        end
        unique case (state_q)
          StIdle: begin
            if (start) begin
              cnt_q <= '0;
`ifdef SC_PREAMBLE_CP_EN
              state_q <= StCp;
`else
              state_q <= StHalf0;
`endif
            end
          end
`ifdef SC_PREAMBLE_CP_EN
          StCp: begin
            if (out_free) begin
              o_tdata_q  <= rd_data;
              o_tvalid_q <= 1'b1;
              if (cnt_q == CpLast) begin
                state_q <= StHalf0;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + CntW'(1);
              end
            end
          end
`endif
          StHalf0: begin
            if (out_free) begin
              o_tdata_q  <= rd_data;
              o_tvalid_q <= 1'b1;
              if (cnt_q == HalfLast) begin
                state_q <= StHalf1;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + CntW'(1);
              end
            end
          end
          StHalf1: begin
            if (out_free) begin
              o_tdata_q  <= rd_data;
              o_tvalid_q <= 1'b1;
              if (cnt_q == HalfLast) begin
                state_q <= StPayload;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + CntW'(1);
              end
            end
          end
          StPayload: begin
            if (in_fire) begin
              o_tdata_q  <= i_axis.tdata;
              o_tlast_q  <= i_axis.tlast;
              o_tvalid_q <= 1'b1;
              if (i_axis.tlast) begin
                state_q <= StIdle;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign i_axis.tready = in_ready;
  assign o_axis.tdata  = o_tdata_q;
  assign o_axis.tlast  = o_tlast_q;
  assign o_axis.tvalid = o_tvalid_q;
  assign pre_wr_err    = pre_wr_err_q;
  assign busy          = (state_q != StIdle);

endmodule
